// File: rtl/oflow_iou_match_scheduler.sv
// ---------------------------------------------------------------------------
// oflow_iou_match_scheduler
//
// Purpose:
//   Initiator side of the IoU cost interface. For one current-frame bbox it
//   walks the first N valid entries of the history bbox buffer. For each
//   entry it reads the history bbox, hands the pair to the IoU calculator
//   (iou_start / valid_iou handshake), collects the returned cost (1 - IoU)
//   and keeps the lowest cost together with its history index.
//
// Ports:
//   clk, reset_N         clock; asynchronous active-high reset
//   start                one-cycle request, only honoured while idle
//   num_valid_hist       entries to scan, clamped to NUM_HIST
//   bbox_k, w_k, h_k     current bbox and its size, captured on start
//   hist_rd_en/addr      history buffer read port (data one cycle later)
//   hist_rd_bbox/w/h     history read data
//   iou_start            one-cycle start pulse to the IoU calculator
//   iou_bbox_k/_hist,
//   iou_w_k/h_k/w_hist/h_hist  registered operand pair for the calculator
//   valid_iou, iou       result strobe and cost from the calculator
//   busy, done           activity flag and one-cycle completion pulse
//   match_found,
//   best_idx, best_cost  scan result, held until the next accepted start
//   timeout_err          sticky: some entry got no answer in time
// ---------------------------------------------------------------------------
module oflow_iou_match_scheduler #(
   parameter int NUM_HIST = 16,
   parameter int COORD_W  = 11,
   parameter int IOU_LEN  = 12,
   parameter int IDX_W    = $clog2(NUM_HIST),
   parameter int TIMEOUT  = 31
) (
   input  logic                   clk,
   input  logic                   reset_N,
   input  logic                   start,
   input  logic [IDX_W:0]         num_valid_hist,
   input  logic [4*COORD_W-1:0]   bbox_k,
   input  logic [COORD_W-1:0]     w_k,
   input  logic [COORD_W-1:0]     h_k,
   output logic                   hist_rd_en,
   output logic [IDX_W-1:0]       hist_rd_addr,
   input  logic [4*COORD_W-1:0]   hist_rd_bbox,
   input  logic [COORD_W-1:0]     hist_rd_w,
   input  logic [COORD_W-1:0]     hist_rd_h,
   output logic                   iou_start,
   output logic [4*COORD_W-1:0]   iou_bbox_k,
   output logic [4*COORD_W-1:0]   iou_bbox_hist,
   output logic [COORD_W-1:0]     iou_w_k,
   output logic [COORD_W-1:0]     iou_h_k,
   output logic [COORD_W-1:0]     iou_w_hist,
   output logic [COORD_W-1:0]     iou_h_hist,
   input  logic                   valid_iou,
   input  logic [IOU_LEN-1:0]     iou,
   output logic                   busy,
   output logic                   done,
   output logic                   match_found,
   output logic [IDX_W-1:0]       best_idx,
   output logic [IOU_LEN-1:0]     best_cost,
   output logic                   timeout_err
);

   localparam int BB_W  = 4*COORD_W;
   localparam int CNT_W = $clog2(TIMEOUT+1);
   localparam logic [IDX_W:0]   N_MAX   = (IDX_W+1)'(NUM_HIST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, ISSUE, WAIT, COMPARE, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W:0]       n_q, n_d;
   logic [BB_W-1:0]      bbox_k_q, bbox_k_d;
   logic [COORD_W-1:0]   w_k_q, w_k_d;
   logic [COORD_W-1:0]   h_k_q, h_k_d;
   logic [BB_W-1:0]      bbox_hist_q, bbox_hist_d;
   logic [COORD_W-1:0]   w_hist_q, w_hist_d;
   logic [COORD_W-1:0]   h_hist_q, h_hist_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IOU_LEN-1:0]   iou_val_q, iou_val_d;
   logic                 skip_q, skip_d;
   logic [IOU_LEN-1:0]   best_cost_q, best_cost_d;
   logic [IDX_W-1:0]     best_idx_q, best_idx_d;
   logic                 match_found_q, match_found_d;
   logic                 timeout_err_q, timeout_err_d;

   logic [IDX_W:0]       n_clamp;
   logic [IDX_W:0]       idx_plus1;

   assign n_clamp   = (num_valid_hist > N_MAX) ? N_MAX : num_valid_hist;
   assign idx_plus1 = {1'b0, idx_q} + (IDX_W+1)'(1);

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      n_d           = n_q;
      bbox_k_d      = bbox_k_q;
      w_k_d         = w_k_q;
      h_k_d         = h_k_q;
      bbox_hist_d   = bbox_hist_q;
      w_hist_d      = w_hist_q;
      h_hist_d      = h_hist_q;
      cnt_d         = cnt_q;
      iou_val_d     = iou_val_q;
      skip_d        = skip_q;
      best_cost_d   = best_cost_q;
      best_idx_d    = best_idx_q;
      match_found_d = match_found_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               bbox_k_d      = bbox_k;
               w_k_d         = w_k;
               h_k_d         = h_k;
               n_d           = n_clamp;
               idx_d         = '0;
               best_cost_d   = '1;
               best_idx_d    = '0;
               match_found_d = 1'b0;
               timeout_err_d = 1'b0;
               state_d       = (n_clamp != '0) ? FETCH : DONE;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            // Read data arrives the cycle after the strobe; these registers
            // are the calculator operands and stay put until the next LOAD.
            bbox_hist_d = hist_rd_bbox;
            w_hist_d    = hist_rd_w;
            h_hist_d    = hist_rd_h;
            state_d     = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            skip_d  = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            // A result arriving on the last allowed cycle still counts.
            if (valid_iou) begin
               iou_val_d = iou;
               state_d   = COMPARE;
            end else if (cnt_q == CNT_MAX) begin
               timeout_err_d = 1'b1;
               skip_d        = 1'b1;
               state_d       = COMPARE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         COMPARE: begin
            // Strict less-than so that ties keep the earliest index.
            if (!skip_q && (iou_val_q < best_cost_q)) begin
               best_cost_d   = iou_val_q;
               best_idx_d    = idx_q;
               match_found_d = 1'b1;
            end
            // idx only advances when another entry follows, so the read
            // address always stays below the clamped count.
            if (idx_plus1 < n_q) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = FETCH;
            end else begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_N) begin
      if (reset_N) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         n_q           <= '0;
         bbox_k_q      <= '0;
         w_k_q         <= '0;
         h_k_q         <= '0;
         bbox_hist_q   <= '0;
         w_hist_q      <= '0;
         h_hist_q      <= '0;
         cnt_q         <= '0;
         iou_val_q     <= '0;
         skip_q        <= 1'b0;
         best_cost_q   <= '1;
         best_idx_q    <= '0;
         match_found_q <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         n_q           <= n_d;
         bbox_k_q      <= bbox_k_d;
         w_k_q         <= w_k_d;
         h_k_q         <= h_k_d;
         bbox_hist_q   <= bbox_hist_d;
         w_hist_q      <= w_hist_d;
         h_hist_q      <= h_hist_d;
         cnt_q         <= cnt_d;
         iou_val_q     <= iou_val_d;
         skip_q        <= skip_d;
         best_cost_q   <= best_cost_d;
         best_idx_q    <= best_idx_d;
         match_found_q <= match_found_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Control strobes decode straight from the state register.
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign hist_rd_en    = (state_q == FETCH);
   assign iou_start     = (state_q == ISSUE);
   assign hist_rd_addr  = idx_q;

   // The current-bbox operands come from the copy captured on start.
   assign iou_bbox_k    = bbox_k_q;
   assign iou_w_k       = w_k_q;
   assign iou_h_k       = h_k_q;
   assign iou_bbox_hist = bbox_hist_q;
   assign iou_w_hist    = w_hist_q;
   assign iou_h_hist    = h_hist_q;

   assign match_found   = match_found_q;
   assign best_idx      = best_idx_q;
   assign best_cost     = best_cost_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_oflow_iou_match_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oflow_iou_match_scheduler
//
// Drives oflow_iou_match_scheduler with a behavioural history buffer and a
// mock IoU calculator. Expected results come from a simple reference model:
// the minimum over the per-entry cost table (skipping withheld entries) and
// the completion cycle from the per-entry cycle cost.
// ---------------------------------------------------------------------------
module tb_oflow_iou_match_scheduler;

   localparam int NUM_HIST = 16;
   localparam int COORD_W  = 11;
   localparam int IOU_LEN  = 12;
   localparam int IDX_W    = 4;
   localparam int TIMEOUT  = 31;
   localparam int BB_W     = 4*COORD_W;

   logic                 clk = 1'b0;
   logic                 reset_N;
   logic                 start;
   logic [IDX_W:0]       num_valid_hist;
   logic [BB_W-1:0]      bbox_k;
   logic [COORD_W-1:0]   w_k, h_k;
   logic                 hist_rd_en;
   logic [IDX_W-1:0]     hist_rd_addr;
   logic [BB_W-1:0]      hist_rd_bbox;
   logic [COORD_W-1:0]   hist_rd_w, hist_rd_h;
   logic                 iou_start;
   logic [BB_W-1:0]      iou_bbox_k, iou_bbox_hist;
   logic [COORD_W-1:0]   iou_w_k, iou_h_k, iou_w_hist, iou_h_hist;
   logic                 valid_iou;
   logic [IOU_LEN-1:0]   iou;
   logic                 busy, done, match_found, timeout_err;
   logic [IDX_W-1:0]     best_idx;
   logic [IOU_LEN-1:0]   best_cost;

   always #5 clk = ~clk;

   oflow_iou_match_scheduler #(
      .NUM_HIST(NUM_HIST), .COORD_W(COORD_W), .IOU_LEN(IOU_LEN),
      .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_N(reset_N), .start(start),
      .num_valid_hist(num_valid_hist), .bbox_k(bbox_k), .w_k(w_k), .h_k(h_k),
      .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
      .hist_rd_bbox(hist_rd_bbox), .hist_rd_w(hist_rd_w), .hist_rd_h(hist_rd_h),
      .iou_start(iou_start), .iou_bbox_k(iou_bbox_k), .iou_bbox_hist(iou_bbox_hist),
      .iou_w_k(iou_w_k), .iou_h_k(iou_h_k), .iou_w_hist(iou_w_hist),
      .iou_h_hist(iou_h_hist), .valid_iou(valid_iou), .iou(iou),
      .busy(busy), .done(done), .match_found(match_found),
      .best_idx(best_idx), .best_cost(best_cost), .timeout_err(timeout_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [BB_W-1:0]    mem_bbox [NUM_HIST];
   logic [COORD_W-1:0] mem_w    [NUM_HIST];
   logic [COORD_W-1:0] mem_h    [NUM_HIST];
   logic [IOU_LEN-1:0] cost_tbl [NUM_HIST];
   logic [NUM_HIST-1:0] hold_mask;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BB_W-1:0] rnd_bbox();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[BB_W-1:0];
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < NUM_HIST; i++) begin
         mem_bbox[i] = rnd_bbox();
         mem_w[i]    = COORD_W'($urandom_range(0, 2047));
         mem_h[i]    = COORD_W'($urandom_range(0, 2047));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},        busy, 0);
      check({tag, "_done"},        done, 0);
      check({tag, "_rd_en"},       hist_rd_en, 0);
      check({tag, "_rd_addr"},     hist_rd_addr, 0);
      check({tag, "_iou_start"},   iou_start, 0);
      check({tag, "_match"},       match_found, 0);
      check({tag, "_timeout"},     timeout_err, 0);
      check({tag, "_best_idx"},    best_idx, 0);
      check({tag, "_best_cost"},   best_cost, 12'hFFF);
      check({tag, "_bbox_k"},      iou_bbox_k, 0);
      check({tag, "_bbox_hist"},   iou_bbox_hist, 0);
      check({tag, "_wh"}, {iou_w_k, iou_h_k, iou_w_hist, iou_h_hist}, 0);
   endtask

   // One full scan: model, stimulus, mock memory/calculator, and checks.
   task automatic run_scan(input string name, input int n_req, input int lat, input bit noise);
      int nc, exp_done, exp_idx;
      logic [IOU_LEN-1:0] exp_cost;
      bit exp_match, exp_to;
      int reads, issues, done_cyc, resp_cyc, resp_entry, hold_until, hold_entry, prev_addr;
      bit prev_rd;
      logic [BB_W-1:0] bk;
      logic [COORD_W-1:0] wk, hk;

      // Reference model.
      nc = (n_req > NUM_HIST) ? NUM_HIST : n_req;
      exp_cost = '1; exp_idx = 0; exp_match = 0; exp_to = 0; exp_done = 1;
      for (int i = 0; i < nc; i++) begin
         if (hold_mask[i]) begin
            exp_to = 1;
            exp_done += 4 + TIMEOUT + 1;
         end else begin
            exp_done += 4 + lat;
            if (cost_tbl[i] < exp_cost) begin
               exp_cost = cost_tbl[i]; exp_idx = i; exp_match = 1;
            end
         end
      end

      bk = rnd_bbox();
      wk = COORD_W'($urandom_range(0, 2047));
      hk = COORD_W'($urandom_range(0, 2047));
      @(posedge clk); #1;
      start = 1'b1;
      num_valid_hist = (IDX_W+1)'(n_req);
      bbox_k = bk; w_k = wk; h_k = hk;

      reads = 0; issues = 0; done_cyc = -1; resp_cyc = -10; resp_entry = 0;
      hold_until = -1; hold_entry = 0; prev_rd = 0; prev_addr = 0;
      for (int cyc = 1; cyc <= exp_done + 8; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0; valid_iou = 1'b0; iou = IOU_LEN'($urandom());
         if (noise) begin
            bbox_k = rnd_bbox(); w_k = COORD_W'($urandom()); h_k = COORD_W'($urandom());
            num_valid_hist = (IDX_W+1)'($urandom_range(0, 31));
         end
         if (prev_rd) begin
            hist_rd_bbox = mem_bbox[prev_addr]; hist_rd_w = mem_w[prev_addr]; hist_rd_h = mem_h[prev_addr];
         end else begin
            hist_rd_bbox = rnd_bbox(); hist_rd_w = COORD_W'($urandom()); hist_rd_h = COORD_W'($urandom());
         end
         prev_rd = 0;

         check({name, "_busy"}, busy, 1);
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (hist_rd_en) begin
            check({name, "_rd_addr"}, hist_rd_addr, reads);
            prev_rd = 1; prev_addr = int'(hist_rd_addr); reads++;
         end
         if (iou_start) begin
            if (issues < nc) begin
               check({name, "_op_hist"}, iou_bbox_hist, mem_bbox[issues]);
               check({name, "_op_whist"}, {iou_w_hist, iou_h_hist}, {mem_w[issues], mem_h[issues]});
               check({name, "_op_k"}, {iou_bbox_k, iou_w_k, iou_h_k}, {bk, wk, hk});
            end
            hold_entry = issues;
            if (issues < NUM_HIST && hold_mask[issues]) begin
               hold_until = cyc + TIMEOUT + 1;
            end else begin
               hold_until = cyc + lat;
               resp_cyc = cyc + lat; resp_entry = issues;
            end
            issues++;
         end else if (cyc <= hold_until && hold_entry < NUM_HIST) begin
            check({name, "_op_stable"}, iou_bbox_hist, mem_bbox[hold_entry]);
         end

         if (cyc == resp_cyc) begin
            valid_iou = 1'b1; iou = cost_tbl[resp_entry];
         end else if (noise && hist_rd_en) begin
            valid_iou = 1'b1; iou = '0;          // spurious strobe during FETCH
         end else if (noise && cyc == resp_cyc + 1) begin
            valid_iou = 1'b1; iou = '0;          // second strobe, same transaction
         end
         if (noise && (cyc % 7 == 3)) start = 1'b1;  // start while busy
      end

      if (done_cyc < 0) begin
         check({name, "_done_seen"}, 0, 1);
      end else begin
         check({name, "_done_cycle"}, done_cyc, exp_done);
         check({name, "_reads"}, reads, nc);
         check({name, "_issues"}, issues, nc);
         check({name, "_best_idx"}, best_idx, exp_idx);
         check({name, "_best_cost"}, best_cost, exp_cost);
         check({name, "_match"}, match_found, exp_match);
         check({name, "_timeout"}, timeout_err, exp_to);
         @(posedge clk); #1;
         valid_iou = 1'b0; start = 1'b0;
         check({name, "_idle_busy"}, busy, 0);
         check({name, "_idle_done"}, done, 0);
         check({name, "_held_cost"}, best_cost, exp_cost);
      end
      $display("scan %s: N=%0d L=%0d done@%0d exp@%0d best_idx=%0d best_cost=%0d to=%0d",
               name, n_req, lat, done_cyc, exp_done, best_idx, best_cost, timeout_err);
   endtask

   task automatic set_costs4(input int c0, input int c1, input int c2, input int c3);
      cost_tbl[0] = IOU_LEN'(c0); cost_tbl[1] = IOU_LEN'(c1);
      cost_tbl[2] = IOU_LEN'(c2); cost_tbl[3] = IOU_LEN'(c3);
   endtask

   task automatic rand_costs(input bit coarse);
      for (int i = 0; i < NUM_HIST; i++)
         cost_tbl[i] = coarse ? IOU_LEN'($urandom_range(0, 15) * 100) : IOU_LEN'($urandom_range(0, 4095));
   endtask

   // Reset while waiting on entry 1, followed by a late result strobe.
   task automatic reset_mid_wait();
      int issues;
      bit prev_rd;
      int prev_addr;
      fill_mem(); hold_mask = '0; set_costs4(100, 50, 60, 70);
      @(posedge clk); #1;
      start = 1'b1; num_valid_hist = 5'd3;
      bbox_k = rnd_bbox(); w_k = 11'd5; h_k = 11'd6;
      issues = 0; prev_rd = 0; prev_addr = 0;
      for (int cyc = 1; cyc < 60 && issues < 2; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0; valid_iou = 1'b0;
         if (prev_rd) begin
            hist_rd_bbox = mem_bbox[prev_addr]; hist_rd_w = mem_w[prev_addr]; hist_rd_h = mem_h[prev_addr];
         end
         prev_rd = hist_rd_en; prev_addr = int'(hist_rd_addr);
         if (iou_start) issues++;
         if (issues == 1 && !iou_start && !hist_rd_en && busy && !valid_iou && cyc == 4 + 3) begin
            valid_iou = 1'b1; iou = cost_tbl[0];   // entry 0 answers with L=4
         end
      end
      check("rst_reached_entry1", issues, 2);
      @(posedge clk); #1;                    // now in WAIT for entry 1
      check("rst_pre_busy", busy, 1);
      check("rst_pre_match", match_found, 1);
      #2 reset_N = 1'b1;
      #1 check_reset_vals("rst_mid");
      @(posedge clk); #1;
      reset_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid_iou = 1'b1; iou = '0;          // late result must be ignored
         @(posedge clk); #1;
         check("rst_late_busy", busy, 0);
         check("rst_late_match", match_found, 0);
         check("rst_late_cost", best_cost, 12'hFFF);
      end
      valid_iou = 1'b0;
      $display("reset mid-wait: busy=%0d match=%0d best_cost=%0d", busy, match_found, best_cost);
   endtask

   initial begin
      reset_N = 1'b1; start = 1'b0; num_valid_hist = '0;
      bbox_k = '0; w_k = '0; h_k = '0;
      hist_rd_bbox = '0; hist_rd_w = '0; hist_rd_h = '0;
      valid_iou = 1'b0; iou = '0;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      reset_N = 1'b0;
      @(posedge clk); #1;

      fill_mem(); hold_mask = '0;
      set_costs4(900, 300, 700, 500);
      run_scan("min_search", 4, 7, 0);

      fill_mem(); set_costs4(200, 200, 4095, 0);
      run_scan("tie_ones", 3, 3, 1);

      run_scan("empty", 0, 5, 0);

      fill_mem(); rand_costs(0); hold_mask = 16'h0004;
      run_scan("clamp_timeout", 20, 4, 0);

      fill_mem(); rand_costs(1); hold_mask = '0;
      run_scan("protocol", 6, 5, 1);

      fill_mem(); rand_costs(1); hold_mask = '0;
      run_scan("lat_max", 2, TIMEOUT + 1, 0);

      for (int r = 0; r < 6; r++) begin
         fill_mem(); rand_costs(r[0]);
         hold_mask = NUM_HIST'($urandom()) & NUM_HIST'($urandom()) & NUM_HIST'($urandom());
         run_scan("random", int'($urandom_range(0, 20)), int'($urandom_range(1, 12)), bit'($urandom_range(0, 1)));
      end

      reset_mid_wait();

      fill_mem(); rand_costs(0); hold_mask = '0;
      run_scan("after_reset", 5, 2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
